// File: rtl/audio_pkg.sv
// Shared types and constants for the song-BRAM sample fetcher.
// Packed words carry four unsigned 8-bit samples, and byte 0 is played first.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    PLAY  = 2'd3
  } fetch_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] SILENCE_DEF = 8'h00;

  function automatic logic [SAMPLE_W-1:0] word_byte(input logic [31:0] word,
                                                    input logic [1:0]  sel);
    return word[SAMPLE_W*sel +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Sample-rate tick generator. It counts from 0 to divisor-1 while enabled and pulses at the top.
// A divisor of 0 or 1 gives a tick on every enabled cycle.
module audio_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] divisor,
  output logic        tick
);

  logic [31:0] count_q, count_d;
  logic [31:0] last;

  // The >= compare lets a shrinking divisor take effect without a 2^32 wrap.
  always_comb begin
    last    = (divisor == 32'd0) ? 32'd0 : divisor - 32'd1;
    tick    = en && (count_q >= last);
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (tick) count_d = '0;
    else if (en)   count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/audio_sample_fetch.sv
// Fetches packed sample words from a synchronous song BRAM and emits one byte per sample tick.
// It handles play/pause, restart, end-of-song and looping.
module audio_sample_fetch
  import audio_pkg::*;
#(
  parameter int                    ADDR_W  = 16,
  parameter logic [SAMPLE_W-1:0]   SILENCE = SILENCE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              restart,
  input  logic              loop_en,
  input  logic [31:0]       divisor,
  input  logic [31:0]       max_index,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        sample_out,
  output logic              sample_tick,
  output logic [31:0]       index,
  output logic              playing,
  output logic              done,
  output fetch_state_t      dbg_state
);

  fetch_state_t        state_q, state_d;
  logic [31:0]         ptr_q, ptr_d;
  logic [31:0]         cur_word_q, cur_word_d;
  logic [31:0]         nxt_word_q, nxt_word_d;
  logic                nxt_valid_q, nxt_valid_d;
  logic                pend_q, pend_d;
  logic                stopped_q, stopped_d;
  logic [7:0]          sample_q, sample_d;
  logic [31:0]         index_q, index_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   word_ptr;
  logic                last_byte, stall, gen_en, gen_clr, gen_tick;

  assign word_ptr  = ptr_q[ADDR_W+1:2];
  assign last_byte = (ptr_q[1:0] == 2'(BYTES_PER_WORD - 1));
  // Consuming byte 3 requires the prefetched word; otherwise the tick is held back.
  assign stall     = last_byte && !nxt_valid_q;
  assign gen_en    = (state_q == PLAY) && play && !stall;
  assign gen_clr   = restart || (state_q != PLAY);

  audio_tick_gen u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (gen_en),
    .clr     (gen_clr),
    .divisor (divisor),
    .tick    (gen_tick)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_word_d  = cur_word_q;
    nxt_word_d  = nxt_word_q;
    nxt_valid_d = nxt_valid_q;
    pend_d      = 1'b0;
    stopped_d   = stopped_q;
    sample_d    = sample_q;
    index_d     = index_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = word_ptr;

    if (pend_q) begin
      nxt_word_d  = mem_rdata;
      nxt_valid_d = 1'b1;
    end

    if (restart) begin
      ptr_d       = '0;
      nxt_valid_d = 1'b0;
      stopped_d   = 1'b0;
      if (play) begin
        state_d  = FILL0;
        mem_en   = 1'b1;
        mem_addr = '0;
      end else begin
        state_d  = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // After a non-looping end, play must drop before the song can start again.
          if (!play) begin
            stopped_d = 1'b0;
          end else if (!stopped_q) begin
            mem_en  = 1'b1;
            state_d = FILL0;
          end
        end
        FILL0: begin
          cur_word_d = mem_rdata;
          mem_en     = 1'b1;
          mem_addr   = word_ptr + ADDR_W'(1);
          state_d    = FILL1;
        end
        FILL1: begin
          nxt_word_d  = mem_rdata;
          nxt_valid_d = 1'b1;
          state_d     = PLAY;
        end
        PLAY: begin
          if (!play) begin
            state_d = IDLE;
          end else if (gen_tick) begin
            if (ptr_q > max_index) begin
              ptr_d       = '0;
              nxt_valid_d = 1'b0;
              if (loop_en) begin
                state_d  = FILL0;
                mem_en   = 1'b1;
                mem_addr = '0;
              end else begin
                state_d   = IDLE;
                done_d    = 1'b1;
                stopped_d = 1'b1;
                sample_d  = SILENCE;
                index_d   = '0;
              end
            end else begin
              sample_d = word_byte(cur_word_q, ptr_q[1:0]);
              index_d  = ptr_q;
              tick_d   = 1'b1;
              ptr_d    = ptr_q + 32'd1;
              if (last_byte) begin
                cur_word_d  = nxt_word_q;
                nxt_valid_d = 1'b0;
                mem_en      = 1'b1;
                mem_addr    = word_ptr + ADDR_W'(2);
                pend_d      = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_word_q  <= '0;
      nxt_word_q  <= '0;
      nxt_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      stopped_q   <= 1'b0;
      sample_q    <= SILENCE;
      index_q     <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_word_q  <= cur_word_d;
      nxt_word_q  <= nxt_word_d;
      nxt_valid_q <= nxt_valid_d;
      pend_q      <= pend_d;
      stopped_q   <= stopped_d;
      sample_q    <= sample_d;
      index_q     <= index_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign sample_out  = sample_q;
  assign sample_tick = tick_q;
  assign index       = index_q;
  assign playing     = (state_q == PLAY);
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
